// File: rtl/dest_router_if.sv
// dest_router bus bundle: VC FIFO read side, D0/D1 write side,
// counters and status.
interface dest_router_if #(
  parameter int BW   = 6,
  parameter int CNTW = 8
);
  logic            enable;
  logic            vc_empty;
  logic [BW-1:0]   vc_data_in;
  logic            vc_rd;
  logic            D0_full;
  logic            D1_full;
  logic            D0_wr;
  logic [BW-1:0]   D0_data_out;
  logic            D1_wr;
  logic [BW-1:0]   D1_data_out;
  logic [CNTW-1:0] D0_count;
  logic [CNTW-1:0] D1_count;
  logic            idle;

  modport master (
    output enable, vc_empty, vc_data_in,
    output D0_full, D1_full,
    input  vc_rd, D0_wr, D0_data_out,
    input  D1_wr, D1_data_out,
    input  D0_count, D1_count, idle
  );

  modport slave (
    input  enable, vc_empty, vc_data_in,
    input  D0_full, D1_full,
    output vc_rd, D0_wr, D0_data_out,
    output D1_wr, D1_data_out,
    output D0_count, D1_count, idle
  );
endinterface

// File: rtl/dest_router.sv
// dest_router: pops a VC FIFO through a 2-entry skid buffer and
// steers each word to D0 or D1 by a destination bit.
module dest_router #(
  parameter int BW       = 6,
  parameter int DEST_BIT = 4,
  parameter int CNTW     = 8
) (
  input logic      clk,
  input logic      reset,
  dest_router_if.slave bus
);

  logic [BW-1:0]   slot0;
  logic [BW-1:0]   slot1;
  logic            hd;
  logic [1:0]      occ;
  logic            rd_pending;
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;

  logic [BW-1:0]   head;
  logic            dest;
  logic            drain;
  logic            wp;
  logic            rd;
  logic [1:0]      lvl;

  // Head routing, read issue and next occupancy.
  // lvl never exceeds 2: reads are only issued when a slot is free.
  always_comb begin
    head  = hd ? slot1 : slot0;
    dest  = head[DEST_BIT];
    drain = (occ != 2'd0) &&
            !(dest ? bus.D1_full : bus.D0_full);
    lvl   = occ + {1'b0, rd_pending} - {1'b0, drain};
    wp    = hd ^ occ[0];
    rd    = bus.enable && !bus.vc_empty && (lvl < 2'd2);
  end

  assign bus.vc_rd       = rd;
  assign bus.D0_wr       = drain && !dest;
  assign bus.D1_wr       = drain && dest;
  assign bus.D0_data_out = (occ != 2'd0) ? head : '0;
  assign bus.D1_data_out = (occ != 2'd0) ? head : '0;
  assign bus.D0_count    = cnt0;
  assign bus.D1_count    = cnt1;
  assign bus.idle        = (occ == 2'd0) && !rd_pending;

  // Skid buffer, pending-read flag and per-destination counters.
  // A capture during a drain at occ=2 reuses the freed head slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot0      <= '0;
      slot1      <= '0;
      hd         <= 1'b0;
      occ        <= 2'd0;
      rd_pending <= 1'b0;
      cnt0       <= '0;
      cnt1       <= '0;
    end else begin
      rd_pending <= rd;
      occ        <= lvl;
      if (drain)
        hd <= ~hd;
      if (rd_pending) begin
        if (wp)
          slot1 <= bus.vc_data_in;
        else
          slot0 <= bus.vc_data_in;
      end
      if (drain && !dest)
        cnt0 <= cnt0 + 1'b1;
      if (drain && dest)
        cnt1 <= cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_dest_router.sv
// Self-checking bench for dest_router: VC FIFO model plus
// per-destination scoreboards and directed scenarios.
module tb_dest_router;
  localparam int BW   = 6;
  localparam int CNTW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dest_router_if #(.BW(BW), .CNTW(CNTW)) bus ();

  dest_router #(
    .BW(BW), .DEST_BIT(4), .CNTW(CNTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  logic [BW-1:0]   vcq[$];
  logic [BW-1:0]   exp0[$];
  logic [BW-1:0]   exp1[$];
  logic [CNTW-1:0] cnt0;
  logic [CNTW-1:0] cnt1;
  logic            rd_s;
  logic            w0;
  logic            w1;
  logic            idle_s;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [BW-1:0] w);
    vcq.push_back(w);
    if (w[4]) exp1.push_back(w);
    else      exp0.push_back(w);
    bus.vc_empty = 1'b0;
  endtask

  // One clock: sample/score at negedge, then drive VC FIFO after edge.
  task automatic tick();
    @(negedge clk);
    rd_s   = bus.vc_rd;
    w0     = bus.D0_wr;
    w1     = bus.D1_wr;
    idle_s = bus.idle;
    if (!reset) begin
      chk("d0_count", bus.D0_count, cnt0);
      chk("d1_count", bus.D1_count, cnt1);
    end
    if (w0) begin
      if (exp0.size() > 0) chk("d0_data", bus.D0_data_out, exp0.pop_front());
      else chk("d0_extra_wr", 1, 0);
    end
    if (w1) begin
      if (exp1.size() > 0) chk("d1_data", bus.D1_data_out, exp1.pop_front());
      else chk("d1_extra_wr", 1, 0);
    end
    if (bus.D0_full) chk("d0_wr_while_full", w0, 0);
    if (bus.D1_full) chk("d1_wr_while_full", w1, 0);
    cnt0 = cnt0 + CNTW'(w0);
    cnt1 = cnt1 + CNTW'(w1);
    @(posedge clk);
    #1;
    if (rd_s) begin
      if (vcq.size() > 0) bus.vc_data_in = vcq.pop_front();
      else chk("vc_rd_on_empty", 1, 0);
    end else begin
      bus.vc_data_in = 6'h2b;
    end
    bus.vc_empty = (vcq.size() == 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    reset          = 1'b1;
    bus.enable     = 1'b0;
    bus.vc_empty   = 1'b1;
    bus.vc_data_in = '0;
    bus.D0_full    = 1'b0;
    bus.D1_full    = 1'b0;
    cnt0           = '0;
    cnt1           = '0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_vc_rd", bus.vc_rd, 0);
    chk("rst_d0_wr", bus.D0_wr, 0);
    chk("rst_d1_wr", bus.D1_wr, 0);
    chk("rst_d0_data", bus.D0_data_out, 0);
    chk("rst_d1_data", bus.D1_data_out, 0);
    chk("rst_d0_cnt", bus.D0_count, 0);
    chk("rst_d1_cnt", bus.D1_count, 0);
    chk("rst_idle", bus.idle, 1);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    bus.enable = 1'b1;
    ticks(3);
    chk("rel_vc_rd", rd_s, 0);
    chk("rel_idle", idle_s, 1);

    // Mixed routing
    for (int i = 1; i <= 4; i++) begin
      push(6'(i));
      push(6'(8'h10 + i));
    end
    tick();
    chk("mix_first_rd", rd_s, 1);
    tick();
    chk("mix_no_wr_t1", w0 | w1, 0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mix_one_wr", w0 + w1, 1);
    end
    ticks(3);
    chk("mix_d0_count", bus.D0_count, 4);
    chk("mix_d1_count", bus.D1_count, 4);
    chk("mix_idle", idle_s, 1);
    chk("mix_sb_empty", exp0.size() + exp1.size(), 0);

    // Fill to full
    for (int i = 0; i < 6; i++) push(6'(i + 1));
    ticks(3);
    bus.D0_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("full_no_d0_wr", w0, 0);
      if (i >= 2) chk("full_rd_low", rd_s, 0);
    end
    chk("full_not_idle", idle_s, 0);
    bus.D0_full = 1'b0;
    ticks(10);
    chk("full_sb_empty", exp0.size(), 0);
    chk("full_idle", idle_s, 1);

    // Head-of-line blocking
    bus.D0_full = 1'b1;
    push(6'h07);
    push(6'h15);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hol_d1_blocked", w1, 0);
    end
    bus.D0_full = 1'b0;
    tick();
    chk("hol_d0_first", {w0, w1}, 2'b10);
    tick();
    chk("hol_d1_next", {w0, w1}, 2'b01);
    ticks(2);
    chk("hol_idle", idle_s, 1);

    // Enable low mid-stream
    for (int i = 0; i < 3; i++) begin
      push(6'(i + 8));
      push(6'(8'h18 + i));
    end
    ticks(3);
    bus.enable = 1'b0;
    tick();
    chk("en_rd_drop", rd_s, 0);
    ticks(4);
    chk("en_idle", idle_s, 1);
    chk("en_left_in_vc", exp0.size() + exp1.size(), vcq.size());
    chk("en_vc_count", vcq.size(), 3);
    bus.enable = 1'b1;
    ticks(8);
    chk("en_sb_empty", exp0.size() + exp1.size(), 0);

    // Reset mid-stream with the buffer full
    bus.D1_full = 1'b1;
    for (int i = 0; i < 4; i++) push(6'(8'h1c + i));
    ticks(5);
    chk("rmid_rd_sat", rd_s, 0);
    reset = 1'b1;
    #1;
    chk("rmid_idle", bus.idle, 1);
    chk("rmid_d1_data", bus.D1_data_out, 0);
    chk("rmid_d0_cnt", bus.D0_count, 0);
    chk("rmid_d1_cnt", bus.D1_count, 0);
    vcq.delete();
    exp0.delete();
    exp1.delete();
    cnt0 = '0;
    cnt1 = '0;
    bus.vc_empty = 1'b1;
    bus.D1_full  = 1'b0;
    ticks(2);
    reset = 1'b0;
    ticks(5);
    chk("rmid_post_idle", idle_s, 1);

    // Counter wrap
    for (int i = 0; i < 257; i++) push(6'h10 | 6'(i % 16));
    ticks(265);
    chk("wrap_d1_count", bus.D1_count, 1);
    chk("wrap_sb_empty", exp1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
